// File: rtl/req_arbiter.sv
// req_arbiter: 12-way fixed-priority/round-robin arbiter with grant hold timeout
module req_arbiter #(
  parameter int N_REQ = 12,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             rr_mode,
  output logic [N_REQ-1:0] gnt,
  output logic [3:0]       gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [3:0] last_id, last_n, id_n, fp_win, rr_win, win, p;
  logic [7:0] cnt, cnt_n;
  logic mask, mask_n, valid_n, to_n;
  logic [N_REQ-1:0] eff;
  assign eff = req & ~(N_REQ'(mask) << last_id);
  always_comb begin
    fp_win = '0;
    rr_win = '0;
    p = '0;
    for (int i = 0; i < N_REQ; i++) begin
      fp_win = eff[i] ? 4'(i) : fp_win;
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      p = 4'((int'(last_id) + 2 * N_REQ - 1 - i) % N_REQ);
      rr_win = eff[p] ? p : rr_win;
    end
    win = rr_mode ? rr_win : fp_win;
  end
  always_comb begin
    state_n = state;
    id_n = gnt_id;
    valid_n = gnt_valid;
    to_n = 1'b0;
    last_n = last_id;
    cnt_n = cnt;
    mask_n = mask;
    if (state == IDLE) begin
      mask_n = 1'b0;
      if (|eff) begin
        state_n = BUSY;
        id_n = win;
        valid_n = 1'b1;
        last_n = win;
        cnt_n = '0;
      end
    end else if (!req[gnt_id] || cnt == 8'(MAX_HOLD - 1)) begin
      state_n = IDLE;
      id_n = '0;
      valid_n = 1'b0;
      to_n = req[gnt_id];
      mask_n = req[gnt_id];
    end else begin
      cnt_n = cnt + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_valid <= 1'b0;
      timeout <= 1'b0;
      last_id <= '0;
      cnt <= '0;
      mask <= 1'b0;
    end else begin
      state <= state_n;
      gnt <= N_REQ'(valid_n) << id_n;
      gnt_id <= id_n;
      gnt_valid <= valid_n;
      timeout <= to_n;
      last_id <= last_n;
      cnt <= cnt_n;
      mask <= mask_n;
    end
  end
endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: scoreboard bench for req_arbiter with MAX_HOLD = 4
module tb_req_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [11:0] req;
  logic rr_mode;
  logic [11:0] gnt;
  logic [3:0] gnt_id;
  logic gnt_valid, timeout;
  typedef struct {int code; int dt;} ev_t;
  ev_t q[$];
  int order[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  logic pv = 1'b0;
  req_arbiter #(.N_REQ(12), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .rr_mode(rr_mode),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic push(input int code, input int dt);
    ev_t e;
    e.code = code;
    e.dt = dt;
    q.push_back(e);
  endtask
  task automatic ev(input int code);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got=%0d at cyc=%0d", code, cyc);
    end else begin
      e = q.pop_front();
      if (code != e.code || (e.dt >= 0 && cyc - last_cyc != e.dt)) begin
        bad++;
        $display("FAIL event got code=%0d dt=%0d want code=%0d dt=%0d", code, cyc - last_cyc, e.code, e.dt);
      end
    end
    last_cyc = cyc;
  endtask
  always @(negedge clk) begin
    chk("onehot", 32'(gnt), gnt_valid ? 32'(12'd1 << gnt_id) : 32'd0);
    if (!gnt_valid) chk("id_idle", 32'(gnt_id), 32'd0);
    if (timeout === 1'b1) ev(100);
    if (gnt_valid === 1'b1 && !pv) ev(int'(gnt_id));
    pv = (gnt_valid === 1'b1);
  end
  task automatic run_order(input logic [11:0] r, input logic rearm);
    req = r;
    foreach (order[i]) begin
      push(order[i], i == 0 ? -1 : 2);
      tick();
      req[order[i]] = 1'b0;
      tick();
      if (rearm) req = r;
    end
    req = '0;
    tick();
  endtask
  initial begin
    rst = 1'b1;
    req = '0;
    rr_mode = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_id", 32'(gnt_id), 32'd0);
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    tick();
    order = {2, 1};
    run_order(12'h007, 1'b0);
    order = {11, 9, 8, 7, 6, 5, 2, 1};
    run_order(12'hBE6, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_mode = 1'b1;
    order = {11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 11};
    run_order(12'hFFF, 1'b1);
    req = 12'h200;
    push(9, -1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_id", 32'(gnt_id), 32'd0);
    chk("midrst_valid", 32'(gnt_valid), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    req = 12'hFFF;
    push(11, 3);
    tick();
    req = '0;
    tick();
    tick();
    rr_mode = 1'b0;
    req = 12'h800;
    push(11, -1);
    push(100, 4);
    push(11, 2);
    repeat (7) tick();
    req = '0;
    tick();
    tick();
    req = 12'h801;
    push(11, -1);
    push(100, 4);
    push(0, 1);
    repeat (6) tick();
    req = '0;
    tick();
    tick();
    req = 12'h801;
    push(11, -1);
    push(11, 5);
    repeat (4) tick();
    req = 12'h001;
    tick();
    req = 12'h801;
    tick();
    req = '0;
    repeat (4) tick();
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/req_arbiter.md
# req_arbiter

Twelve-requester arbiter for the shared resource behind the priority encoder. It picks one requester, using either fixed priority (highest index wins) or round-robin. It holds that grant until the requester releases it or a hold timeout expires. It drives a one-hot grant vector plus the encoded 4-bit winner index, and sits between the requesting units and the shared datapath.

## Interface
- `N_REQ`, 12, number of requesters; fixed at 12, and the index width is 4.
- `MAX_HOLD`, 16, maximum consecutive cycles one grant may be held; legal range 2..256.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  12  request vector; bit i high means requester i wants the resource.
- `rr_mode`  in  1  0 selects fixed priority, 1 selects round-robin; sampled only in IDLE.
- `gnt`  out  12  one-hot grant, registered; all zero when nothing is granted.
- `gnt_id`  out  4  index of the granted requester, registered; 0 when `gnt_valid` is 0.
- `gnt_valid`  out  1  high while a grant is held.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- Reset values:
  - `gnt` = 0, `gnt_id` = 0, `gnt_valid` = 0, `timeout` = 0.
  - State = IDLE; last-grant pointer `last_id` = 0; hold counter = 0; mask flag clear.
- IDLE state:
  - Arbitrates over the effective request set: `req`, with bit `last_id` cleared if the mask flag is set.
  - If the set is non-empty: register the winner, go to BUSY, and clear the hold counter.
  - If the set is empty: stay in IDLE.
  - The mask flag clears on every IDLE cycle, whether or not a grant is issued.
- Fixed priority: the highest set index wins, so `req` = 0000_0000_0111 gives winner 2.
- Round-robin:
  - Search order starts at (`last_id` − 1) mod 12 and descends, wrapping from 0 to 11.
  - `last_id` itself is searched last.
  - After reset (`last_id` = 0) the order is 11 down to 0, identical to fixed priority.
- `last_id` updates to the winner on every grant, in both modes.
- BUSY state:
  - Each cycle, if `req[gnt_id]` is 0: release. Go to IDLE and drop the grant at the same edge.
  - Otherwise, if the hold counter equals `MAX_HOLD` − 1: revoke. Go to IDLE, drop the grant, pulse `timeout`, and set the mask flag.
  - Otherwise: increment the hold counter.
- Other requests are ignored while in BUSY; there is no preemption.
- The hold counter is 8 bits wide, counts from 0, and never wraps, because the revoke limit bounds it.
- `rr_mode` changes while in BUSY take effect at the next IDLE arbitration.

## Timing
- Grant latency: `req` sampled in IDLE at edge k means `gnt`, `gnt_id` and `gnt_valid` are valid after edge k.
- The grant is held for a total of at most `MAX_HOLD` cycles.
- Release: `req[gnt_id]` low, sampled at edge k, means the grant is low after edge k.
  - The next cycle is IDLE, so there is at least one dead cycle between consecutive grants.
  - The earliest next grant is after edge k+1.
- Timeout: the grant is high for exactly `MAX_HOLD` cycles, then drops.
  - `timeout` is high for exactly the one cycle following the revoke edge, which is the IDLE cycle.
- Masked requester alone:
  - The IDLE cycle issues no grant and the mask clears.
  - The same requester is granted at the following edge.
  - Gap after a timeout in this case: 2 cycles.
- Simultaneous release and timeout in the same cycle: treated as a release; no `timeout` pulse and no mask.
- Reset mid-grant: outputs reach their reset values after the reset edge.
  - `last_id` returns to 0 and any pending mask is dropped.
- `gnt` is always one-hot or zero, and always equals the decode of `gnt_id` when `gnt_valid` = 1.

## Test plan
- Fixed priority:
  - Stimulus: `rr_mode` = 0, `req` = 0000_0000_0111 from IDLE.
  - Required response: `gnt_id` = 2 and `gnt` = 0x004 one cycle later; drop `req[2]`, and the grant falls; next arbitration grants 1.
- Fixed priority, wide pattern:
  - Stimulus: `req` = 1011_1110_0110, held by each winner until released.
  - Required response: grant order 11, 9, 8, 7, 6, 5, 2, 1, with one dead cycle between grants.
- Round-robin fairness:
  - Stimulus: `rr_mode` = 1, `req` = 0xFFF held; each winner releases after 1 cycle and re-asserts immediately.
  - Required response: grant sequence 11, 10, …, 0, 11; each index granted once per 12 grants.
- Timeout:
  - Stimulus: `MAX_HOLD` = 4, `req` = 0x800 held forever.
  - Required response: grant 11 for 4 cycles, `timeout` pulse, an IDLE cycle with no grant, then grant 11 again.
  - With `req` = 0x801 instead: after the timeout, 0 is granted in the IDLE arbitration.
- Reset mid-grant:
  - Stimulus: `rst` asserted for 1 cycle while `gnt_id` = 9 in round-robin mode.
  - Required response: all outputs 0 after the edge; with `req` = 0xFFF, the next grant is 11.
- Release on the timeout cycle:
  - Stimulus: `MAX_HOLD` = 4; drop `req[id]` in the 4th held cycle.
  - Required response: no `timeout` pulse, and the requester is not masked at the next arbitration.
